multi_channel_freq_meter: RTL
=============================

// Module: multi_channel_freq_meter
// PURPOSE
//  Parametrised measurement core for the frequency meter; successor to the fixed A/B, 2-bit-opcode core.
//  Measures one of N_CH asynchronous inputs, selected per measurement, in one of four modes:
//  frequency, period, duty, or phase against a second selectable channel.
//  Adds a start/busy/done handshake, a timeout and counter saturation.
//  Sits between the mode-select logic and the UART report formatter, in the clk domain.
// PARAMETERS
//  N_CH            4        number of measured input channels (>=2)
//  CNT_W           32       width of result counters
//  GATE_CYCLES     50000000 clk cycles in the FREQ gate window (>=1)
//  TIMEOUT_CYCLES  2**26    max clk cycles spent in ARM+MEAS for PERIOD/DUTY/PHASE modes
// PORTS
//  clk       in   1                  system clock
//  rst_n     in   1                  synchronous reset, active low
//  sig       in   N_CH               asynchronous measured inputs
//  start     in   1                  one-cycle request; ignored while busy=1
//  mode      in   2                  00 FREQ, 01 PERIOD, 10 DUTY, 11 PHASE; latched at start
//  ch_sel    in   $clog2(N_CH)       measured channel; latched at start
//  ref_sel   in   $clog2(N_CH)       PHASE reference channel; latched at start
//  busy      out  1                  measurement in progress
//  done      out  1                  one-cycle pulse, results valid
//  result_a  out  CNT_W              primary result; held until next accepted start
//  result_b  out  CNT_W              DUTY period count; 0 in other modes
//  ovf       out  1                  a counter saturated during the last measurement
//  timeout   out  1                  last measurement timed out
// BEHAVIOUR
//  - Clock and reset: single clk domain. rst_n is sampled on clk.
//  - Reset: all outputs are 0 and the FSM is in IDLE. Synchronizers are cleared to 0.
//  - Reset mid-operation aborts the measurement; no done pulse is issued.
//  - Input conditioning: each sig bit passes through a 2-flop synchronizer and then an edge detector.
//  - Edge latency: a rise/fall is visible 3 cycles after the input transition.
//  - Start handshake: start=1 in IDLE or DONE is accepted.
//    On acceptance: busy=1 next cycle; ovf, timeout, result_a and result_b are cleared; mode/ch_sel/ref_sel are latched.
//  - FSM states: IDLE -> ARM -> MEAS -> DONE -> IDLE; DONE lasts exactly 1 cycle; done=1 only in DONE.
//  - busy=1 in ARM and MEAS.
//  - FREQ mode: ARM is skipped.
//    MEAS lasts exactly GATE_CYCLES cycles; result_a = number of synced rising edges of ch seen in those cycles.
//  - PERIOD mode: ARM waits for a rising edge of ch (cycle t0). MEAS ends at the next rising edge (t1).
//    result_a = t1 - t0.
//  - DUTY mode: ARM waits for a rise at t0; a fall is then seen at tf and the next rise at t1.
//    result_a = tf - t0; result_b = t1 - t0.
//  - PHASE mode: ARM waits for a rise of ch (t0); MEAS ends on the first rise of ref at t1 > t0.
//    result_a = t1 - t0.
//    A ref rise in the same cycle as t0 ends immediately with result_a = 0.
//    ch_sel == ref_sel is legal and behaves as PERIOD.
//  - Timeout (non-FREQ modes): a cycle counter starts at acceptance.
//    When it reaches TIMEOUT_CYCLES in ARM or MEAS: go to DONE, timeout=1, result_a = result_b = all-ones.
//  - Saturation: every counter stops at 2**CNT_W-1 instead of wrapping, and ovf=1.
//    The measurement otherwise completes normally.
//  - start asserted in the DONE cycle is accepted; the next measurement begins without an IDLE cycle.
//  - ovf and timeout hold until the next accepted start or reset.
// TESTING  (GATE_CYCLES=1000, TIMEOUT_CYCLES=4096, N_CH=4, CNT_W=16)
//  1. FREQ, ch 2, square wave of period 10 clk -> done after ~1001 cycles; result_a in {99,100,101}; ovf=0.
//  2. PERIOD / DUTY, ch 1, period 10, high 3 -> PERIOD result_a=10; DUTY result_a=3, result_b=10.
//  3. PHASE, ch0 period 20, ch3 same wave delayed 7 clk -> result_a=7.
//     Same test with zero delay -> result_a=0.
//  4. PERIOD on a constant-0 input -> done 4096 cycles after start; timeout=1; result_a=16'hFFFF.
//  5. CNT_W=8, FREQ with an input toggling every cycle -> result_a=8'hFF; ovf=1.
//  6. start pulsed while busy -> ignored, latched mode unchanged.
//     rst_n=0 for 1 cycle mid-MEAS -> busy=0, results 0, no done.
//     A following start is accepted normally.

Source files
------------

// File: rtl/multi_channel_freq_meter.sv
// Multi-channel frequency/period/duty/phase measurement core with start/busy/done handshake,
// per-measurement timeout and saturating result counters.
module multi_channel_freq_meter #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 32,
    parameter int GATE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 2**26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          sig,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [$clog2(N_CH)-1:0]  ch_sel,
    input  logic [$clog2(N_CH)-1:0]  ref_sel,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         result_a,
    output logic [CNT_W-1:0]         result_b,
    output logic                     ovf,
    output logic                     timeout
);

    localparam int SEL_W   = $clog2(N_CH);
    localparam int TMR_MAX = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1) + 1;

    localparam logic [1:0] M_FREQ   = 2'b00;
    localparam logic [1:0] M_PERIOD = 2'b01;
    localparam logic [1:0] M_DUTY   = 2'b10;
    localparam logic [1:0] M_PHASE  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] GATE_END = TMR_W'(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [SEL_W-1:0]   ref_q, ref_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   res_a_q, res_a_d;
    logic [CNT_W-1:0]   res_b_q, res_b_d;
    logic               ovf_q, ovf_d;
    logic               timeout_q, timeout_d;
    logic               fell_q, fell_d;

    logic [N_CH-1:0]    sync1_q, sync1_d;
    logic [N_CH-1:0]    sync2_q, sync2_d;
    logic [N_CH-1:0]    prev_q, prev_d;

    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    fall;
    logic               ch_rise, ch_fall, ref_rise, end_rise;
    logic               cnt_sat, tmo_hit, accept;
    logic [CNT_W-1:0]   cnt_inc;

    // Two-flop synchronizer followed by a one-flop edge detector per channel.
    always_comb begin
        sync1_d = sig;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        fall    = ~sync2_q & prev_q;
    end

    always_comb begin
        ch_rise  = rise[ch_q];
        ch_fall  = fall[ch_q];
        ref_rise = rise[ref_q];
        end_rise = (mode_q == M_PHASE) ? ref_rise : ch_rise;
        cnt_sat  = (cnt_q == CNT_MAX);
        cnt_inc  = cnt_sat ? cnt_q : cnt_q + 1'b1;
        tmo_hit  = (timer_q >= TMO_LAST);
        accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ch_d      = ch_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        ovf_d     = ovf_q;
        timeout_d = timeout_q;
        fell_d    = fell_q;

        case (state_q)
            S_IDLE: ;
            S_DONE: state_d = S_IDLE;
            S_ARM: begin
                timer_d = timer_q + 1'b1;
                if (ch_rise) begin
                    // A reference rise coincident with t0 is a zero phase, unless ref is ch itself.
                    if ((mode_q == M_PHASE) && ref_rise && (ref_q != ch_q)) begin
                        res_a_d = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                        fell_d  = 1'b0;
                        state_d = S_MEAS;
                    end
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    res_a_d   = CNT_MAX;
                    res_b_d   = CNT_MAX;
                    state_d   = S_DONE;
                end
            end
            S_MEAS: begin
                timer_d = timer_q + 1'b1;
                if (mode_q == M_FREQ) begin
                    if (ch_rise) begin
                        cnt_d = cnt_inc;
                        if (cnt_sat) ovf_d = 1'b1;
                    end
                    if (timer_q >= GATE_END) begin
                        res_a_d = ch_rise ? cnt_inc : cnt_q;
                        state_d = S_DONE;
                    end
                end else begin
                    // cnt_q holds (current cycle - t0) throughout MEAS.
                    if ((mode_q == M_DUTY) && ch_fall && !fell_q) begin
                        res_a_d = cnt_q;
                        fell_d  = 1'b1;
                    end
                    if (end_rise) begin
                        if (mode_q == M_DUTY) res_b_d = cnt_q;
                        else                  res_a_d = cnt_q;
                        state_d = S_DONE;
                    end else if (tmo_hit) begin
                        timeout_d = 1'b1;
                        res_a_d   = CNT_MAX;
                        res_b_d   = CNT_MAX;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_sat) ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance also overrides DONE->IDLE so back-to-back measurements skip IDLE.
        if (accept) begin
            state_d   = (mode == M_FREQ) ? S_MEAS : S_ARM;
            mode_d    = mode;
            ch_d      = ch_sel;
            ref_d     = ref_sel;
            cnt_d     = '0;
            timer_d   = {{(TMR_W-1){1'b0}}, 1'b1};
            res_a_d   = '0;
            res_b_d   = '0;
            ovf_d     = 1'b0;
            timeout_d = 1'b0;
            fell_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            ch_q      <= '0;
            ref_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            res_a_q   <= '0;
            res_b_q   <= '0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            fell_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            ch_q      <= ch_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            res_a_q   <= res_a_d;
            res_b_q   <= res_b_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
            fell_q    <= fell_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
        end
    end

    assign busy     = (state_q == S_ARM) || (state_q == S_MEAS);
    assign done     = (state_q == S_DONE);
    assign result_a = res_a_q;
    assign result_b = res_b_q;
    assign ovf      = ovf_q;
    assign timeout  = timeout_q;

endmodule
